// File: rtl/hex_scroll_pkg.sv
// hex_scroll_pkg
//   Shared definitions for the scrolling-display decoder:
//   - char_t: 4-bit character codes recovered from the 7-segment displays
//   - SEG_*: active-low segment patterns (bit 6 = segment g ... bit 0 = segment a)
//   - seg_to_char(): pattern -> character code, CH_UNKNOWN for anything else
//   - LEDR_ALL_ON: LED bar value that marks end-of-message
package hex_scroll_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [9:0] LEDR_ALL_ON = 10'h3FF;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_C    = 7'b1000110;
  localparam logic [6:0] SEG_P    = 7'b0001100;
  localparam logic [6:0] SEG_E    = 7'b0000110;
  localparam logic [6:0] SEG_N    = 7'b1001000;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_B    = 7'b0000011;
  localparam logic [6:0] SEG_Y    = 7'b0010001;
  localparam logic [6:0] SEG_E_LC = 7'b0000100;

  typedef enum logic [3:0] {
    CH_BLANK   = 4'd0,
    CH_C       = 4'd1,
    CH_P       = 4'd2,
    CH_E       = 4'd3,
    CH_N       = 4'd4,
    CH_3       = 4'd5,
    CH_1       = 4'd6,
    CH_B       = 4'd7,
    CH_Y       = 4'd8,
    CH_E_LC    = 4'd9,
    CH_UNKNOWN = 4'd15
  } char_t;

  function automatic char_t seg_to_char(input logic [6:0] seg);
    char_t ch;
    case (seg)
      SEG_OFF:  ch = CH_BLANK;
      SEG_C:    ch = CH_C;
      SEG_P:    ch = CH_P;
      SEG_E:    ch = CH_E;
      SEG_N:    ch = CH_N;
      SEG_3:    ch = CH_3;
      SEG_1:    ch = CH_1;
      SEG_B:    ch = CH_B;
      SEG_Y:    ch = CH_Y;
      SEG_E_LC: ch = CH_E_LC;
      default:  ch = CH_UNKNOWN;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/char_fifo.sv
// char_fifo
//   First-word-fall-through FIFO. pop_data_o always shows the head entry;
//   it is meaningful while empty_o is low.
//   Handshake: a push is accepted when push_i is high and the FIFO is not
//   full, or when it is full and a pop happens in the same cycle. A pop is
//   accepted when pop_i is high and the FIFO is not empty. A push refused
//   because the FIFO is full is simply discarded; the caller decides what
//   to flag.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push_i, push_data_i write request and data
//   pop_i               remove head entry
//   pop_data_o          head entry
//   full_o, empty_o     occupancy status
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module char_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o    = (cnt_q == '0);
  assign full_o     = (cnt_q == FULL_CNT);
  assign pop_data_o = mem_q[rd_ptr_q];

  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/hex_scroll_decoder.sv
// hex_scroll_decoder
//   Passive reader for a six-digit scrolling 7-segment display. Each frame
//   sampled from HEX5..HEX0 is decoded to character codes and compared with
//   the previously accepted frame:
//     unchanged                  -> nothing happens
//     shifted left by one digit  -> scroll step: the new HEX0 character is
//                                   queued and the step counter advances
//     anything else              -> FRAME_ERR (sticky)
//   The character queue is drained with a valid/ready handshake: a character
//   transfers on any rising edge where CHAR_VALID and CHAR_READY are both
//   high; CHAR_DATA is stable while CHAR_VALID is high and not accepted.
// Ports:
//   CLOCK_50, RESET_N     clock, asynchronous active-low reset
//   HEX5..HEX0            active-low segment buses (HEX5 leftmost)
//   LEDR                  LED bar of the scrolling display
//   CHAR_DATA/VALID/READY queued character stream
//   SCROLL_COUNT          saturating count of scroll steps
//   FRAME_ERR, BAD_GLYPH, OVERFLOW, DONE  sticky status flags
// Build option GLITCH_FILTER_EN: a frame is only classified after it has
//   been sampled identically on two consecutive edges, so a one-cycle glitch
//   produces no event (latency 3 cycles instead of 2).
module hex_scroll_decoder
  import hex_scroll_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int COUNT_W = 8
) (
  input  logic               CLOCK_50,
  input  logic               RESET_N,
  input  logic [6:0]         HEX5,
  input  logic [6:0]         HEX4,
  input  logic [6:0]         HEX3,
  input  logic [6:0]         HEX2,
  input  logic [6:0]         HEX1,
  input  logic [6:0]         HEX0,
  input  logic [9:0]         LEDR,
  output logic [3:0]         CHAR_DATA,
  output logic               CHAR_VALID,
  input  logic               CHAR_READY,
  output logic [COUNT_W-1:0] SCROLL_COUNT,
  output logic               FRAME_ERR,
  output logic               BAD_GLYPH,
  output logic               OVERFLOW,
  output logic               DONE
);

  // Sample register: raw segment patterns, index 5 = HEX5.
  logic [NUM_DIGITS-1:0][6:0] hex_s_q, hex_s_d;
  logic [9:0]                 ledr_s_q, ledr_s_d;

`ifdef GLITCH_FILTER_EN
  // Holds the sample taken one edge earlier; a frame counts only once it
  // has been seen on two consecutive edges.
  logic [NUM_DIGITS-1:0][6:0] hex_h_q, hex_h_d;
  logic [9:0]                 ledr_h_q, ledr_h_d;
`endif

  // Decoded sample and last accepted frame (character codes).
  logic [NUM_DIGITS-1:0][3:0] frame;
  logic [NUM_DIGITS-1:0][3:0] prev_q, prev_d;

  logic [COUNT_W-1:0] count_q, count_d;
  logic               frame_err_q, frame_err_d;
  logic               bad_glyph_q, bad_glyph_d;
  logic               overflow_q, overflow_d;
  logic               done_q, done_d;

  logic classify;
  logic frame_bad;
  logic frame_changed;
  logic frame_shift;
  logic frame_blank;
  logic push;
  logic pop;
  logic fifo_full;
  logic fifo_empty;
  logic [3:0] fifo_head;

  // ---------------------------------------------------------------------
  // Input sampling
  // ---------------------------------------------------------------------
  always_comb begin
    hex_s_d  = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
    ledr_s_d = LEDR;
`ifdef GLITCH_FILTER_EN
    hex_h_d  = hex_s_q;
    ledr_h_d = ledr_s_q;
`endif
  end

`ifdef GLITCH_FILTER_EN
  assign classify = (hex_s_q == hex_h_q) && (ledr_s_q == ledr_h_q);
`else
  assign classify = 1'b1;
`endif

  // ---------------------------------------------------------------------
  // Decode and classify
  // ---------------------------------------------------------------------
  always_comb begin
    frame     = '0;
    frame_bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      frame[i] = seg_to_char(hex_s_q[i]);
      if (frame[i] == CH_UNKNOWN) begin
        frame_bad = 1'b1;
      end
    end
  end

  // A shift means every digit moved one place left: HEX(i) now shows what
  // HEX(i-1) showed. The incoming HEX0 character is unconstrained, so a
  // repeated letter entering at HEX0 is still a step.
  assign frame_changed = (frame != prev_q);
  assign frame_shift   = (frame[NUM_DIGITS-1:1] == prev_q[NUM_DIGITS-2:0]);
  // CH_BLANK is code 0, so an all-blank frame is all-zero.
  assign frame_blank   = (frame == '0);

  assign push = classify && frame_changed && frame_shift;
  assign pop  = !fifo_empty && CHAR_READY;

  always_comb begin
    prev_d      = prev_q;
    count_d     = count_q;
    frame_err_d = frame_err_q;
    bad_glyph_d = bad_glyph_q;
    overflow_d  = overflow_q;
    done_d      = done_q;

    if (classify) begin
      prev_d = frame;
      if (frame_bad) begin
        bad_glyph_d = 1'b1;
      end
      if (frame_changed && !frame_shift) begin
        frame_err_d = 1'b1;
      end
      if ((ledr_s_q == LEDR_ALL_ON) && frame_blank) begin
        done_d = 1'b1;
      end
    end

    // Every step counts, even when its character is dropped.
    if (push && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end

    if (push && fifo_full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Character queue
  // ---------------------------------------------------------------------
  char_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (4)
  ) u_char_fifo (
    .clk         (CLOCK_50),
    .rst_n       (RESET_N),
    .push_i      (push),
    .push_data_i (frame[0]),
    .pop_i       (pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      // Samples reset to a blank frame so the first classification after
      // reset matches the blank previous frame and raises nothing.
      hex_s_q     <= {NUM_DIGITS{SEG_OFF}};
      ledr_s_q    <= '0;
`ifdef GLITCH_FILTER_EN
      hex_h_q     <= {NUM_DIGITS{SEG_OFF}};
      ledr_h_q    <= '0;
`endif
      prev_q      <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      bad_glyph_q <= 1'b0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      hex_s_q     <= hex_s_d;
      ledr_s_q    <= ledr_s_d;
`ifdef GLITCH_FILTER_EN
      hex_h_q     <= hex_h_d;
      ledr_h_q    <= ledr_h_d;
`endif
      prev_q      <= prev_d;
      count_q     <= count_d;
      frame_err_q <= frame_err_d;
      bad_glyph_q <= bad_glyph_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
    end
  end

  assign CHAR_DATA    = fifo_head;
  assign CHAR_VALID   = !fifo_empty;
  assign SCROLL_COUNT = count_q;
  assign FRAME_ERR    = frame_err_q;
  assign BAD_GLYPH    = bad_glyph_q;
  assign OVERFLOW     = overflow_q;
  assign DONE         = done_q;

endmodule

// File: tb/tb_hex_scroll_decoder.sv
module tb_hex_scroll_decoder;

  localparam int DEPTH     = 8;
  localparam int COUNT_W   = 8;
  localparam int COUNT_MAX = (1 << COUNT_W) - 1;
`ifdef GLITCH_FILTER_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic               CLOCK_50 = 1'b0;
  logic               RESET_N  = 1'b0;
  logic [5:0][6:0]    hex_in;
  logic [9:0]         LEDR;
  logic               CHAR_READY;
  logic [3:0]         CHAR_DATA;
  logic               CHAR_VALID;
  logic [COUNT_W-1:0] SCROLL_COUNT;
  logic               FRAME_ERR;
  logic               BAD_GLYPH;
  logic               OVERFLOW;
  logic               DONE;

  always #5 CLOCK_50 = ~CLOCK_50;

  hex_scroll_decoder #(
    .DEPTH   (DEPTH),
    .COUNT_W (COUNT_W)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .RESET_N      (RESET_N),
    .HEX5         (hex_in[5]),
    .HEX4         (hex_in[4]),
    .HEX3         (hex_in[3]),
    .HEX2         (hex_in[2]),
    .HEX1         (hex_in[1]),
    .HEX0         (hex_in[0]),
    .LEDR         (LEDR),
    .CHAR_DATA    (CHAR_DATA),
    .CHAR_VALID   (CHAR_VALID),
    .CHAR_READY   (CHAR_READY),
    .SCROLL_COUNT (SCROLL_COUNT),
    .FRAME_ERR    (FRAME_ERR),
    .BAD_GLYPH    (BAD_GLYPH),
    .OVERFLOW     (OVERFLOW),
    .DONE         (DONE)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  // Glyph table indexed by character code 0..9.
  logic [6:0] seg_tab [10] = '{7'h7F, 7'b1000110, 7'b0001100, 7'b0000110,
                               7'b1001000, 7'b0110000, 7'b1111001,
                               7'b0000011, 7'b0010001, 7'b0000100};

  logic [3:0]      exp_q [$];   // characters the consumer should see, in order
  logic [5:0][3:0] m_prev;      // last accepted frame
  logic [5:0][6:0] m_s1, m_s2;  // newest and older sampled raw frames
  logic [9:0]      m_l1, m_l2;
  int              m_count;
  bit              m_ferr, m_bad, m_ovf, m_done;
  logic [5:0][3:0] cur;         // characters currently driven

  function automatic logic [3:0] decode(input logic [6:0] s);
    for (int i = 0; i < 10; i++) begin
      if (s == seg_tab[i]) return 4'(i);
    end
    return 4'd15;
  endfunction

  task automatic model_reset();
    m_prev  = '0;
    m_s1    = {6{7'h7F}};
    m_s2    = {6{7'h7F}};
    m_l1    = '0;
    m_l2    = '0;
    exp_q.delete();
    m_count = 0;
    m_ferr  = 0;
    m_bad   = 0;
    m_ovf   = 0;
    m_done  = 0;
  endtask

  // Called just after each rising edge with the inputs that edge saw.
  task automatic model_update();
    logic [5:0][3:0] f;
    logic [5:0][6:0] fr_hex;
    logic [9:0]      fr_l;
    bit cls, pop, push, shifted;
    if (!RESET_N) begin
      model_reset();
      return;
    end
    pop = (exp_q.size() != 0) && CHAR_READY;
`ifdef GLITCH_FILTER_EN
    cls = (m_s1 == m_s2) && (m_l1 == m_l2);
`else
    cls = 1;
`endif
    fr_hex = m_s1;
    fr_l   = m_l1;
    m_s2   = m_s1;
    m_l2   = m_l1;
    m_s1   = hex_in;
    m_l1   = LEDR;
    push   = 0;
    f      = '0;
    if (cls) begin
      for (int i = 0; i < 6; i++) begin
        f[i] = decode(fr_hex[i]);
        if (f[i] == 4'd15) m_bad = 1;
      end
      shifted = 1;
      for (int i = 1; i < 6; i++) begin
        if (f[i] != m_prev[i-1]) shifted = 0;
      end
      if (f != m_prev) begin
        if (shifted) push = 1;
        else m_ferr = 1;
      end
      if (fr_l == 10'h3FF && f == '0) m_done = 1;
      m_prev = f;
    end
    if (pop) void'(exp_q.pop_front());
    if (push) begin
      if (m_count < COUNT_MAX) m_count++;
      if (exp_q.size() < DEPTH) exp_q.push_back(f[0]);
      else m_ovf = 1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge CLOCK_50);
    model_update();
    @(negedge CLOCK_50);
  endtask

  task automatic set_frame(input logic [5:0][3:0] c);
    cur = c;
    for (int i = 0; i < 6; i++) begin
      hex_in[i] = (c[i] <= 4'd9) ? seg_tab[c[i]] : 7'h55;
    end
  endtask

  task automatic shift_in(input logic [3:0] ch);
    set_frame({cur[4:0], ch});
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    model_reset();
    RESET_N = 1'b0;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 6; i++) hex_in[i] = 7'($urandom_range(0, 127));
      LEDR       = 10'($urandom);
      CHAR_READY = 1'($urandom_range(0, 1));
      cycle();
      checks++;
      if ({CHAR_DATA, CHAR_VALID, SCROLL_COUNT, FRAME_ERR, BAD_GLYPH, OVERFLOW, DONE} !== '0) begin
        failures++;
        $display("FAIL reset_outputs: data=%0d valid=%b count=%0d ferr=%b bad=%b ovf=%b done=%b, expected all 0",
                 CHAR_DATA, CHAR_VALID, SCROLL_COUNT, FRAME_ERR, BAD_GLYPH, OVERFLOW, DONE);
      end
    end
    set_frame('0);
    LEDR       = '0;
    CHAR_READY = 1'b0;
    RESET_N    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      checks++;
      if (CHAR_VALID !== 1'b0 || SCROLL_COUNT !== '0 || FRAME_ERR !== 1'b0) begin
        failures++;
        $display("FAIL idle_blank: valid=%b count=%0d ferr=%b, expected 0 0 0",
                 CHAR_VALID, SCROLL_COUNT, FRAME_ERR);
      end
    end
  endtask

  task automatic test_scroll_basic();
    logic [3:0] seen [$];
    CHAR_READY = 1'b1;
    for (int s = 1; s <= 3; s++) begin
      shift_in(4'(s));   // -----C, ----CP, ---CPE
      for (int k = 0; k < 4; k++) begin
        cycle();
        checks++;
        if (CHAR_VALID !== (exp_q.size() != 0)) begin
          failures++;
          $display("FAIL basic_valid: got %b expected %b", CHAR_VALID, exp_q.size() != 0);
        end
        if (CHAR_VALID === 1'b1) seen.push_back(CHAR_DATA);
      end
    end
    checks++;
    if (seen.size() != 3) begin
      failures++;
      $display("FAIL basic_valid_cycles: got %0d expected 3", seen.size());
    end
    for (int i = 0; i < seen.size() && i < 3; i++) begin
      checks++;
      if (seen[i] !== 4'(i + 1)) begin
        failures++;
        $display("FAIL basic_char%0d: got %0d expected %0d", i, seen[i], i + 1);
      end
    end
    checks++;
    if (SCROLL_COUNT !== 8'd3 || FRAME_ERR !== 1'b0) begin
      failures++;
      $display("FAIL basic_count: count=%0d ferr=%b expected 3 0", SCROLL_COUNT, FRAME_ERR);
    end
  endtask

  task automatic test_frame_err();
    CHAR_READY = 1'b1;
    set_frame({6{4'd4}});  // NNNNNN
    for (int k = 0; k < 4; k++) begin
      cycle();
      checks++;
      if (CHAR_VALID !== 1'b0) begin
        failures++;
        $display("FAIL ferr_nopush: valid=%b expected 0", CHAR_VALID);
      end
    end
    checks++;
    if (FRAME_ERR !== 1'b1 || SCROLL_COUNT !== 8'd3) begin
      failures++;
      $display("FAIL ferr_flag: ferr=%b count=%0d expected 1 3", FRAME_ERR, SCROLL_COUNT);
    end
  endtask

  task automatic test_overflow();
    logic [3:0] sent [$];
    logic [3:0] got [$];
    logic [3:0] ch;
    CHAR_READY = 1'b0;
    for (int s = 0; s < 9; s++) begin
      ch = 4'($urandom_range(1, 9));
      if ({cur[4:0], ch} == cur) ch = (ch == 4'd9) ? 4'd1 : ch + 4'd1;
      shift_in(ch);
      sent.push_back(ch);
      for (int k = 0; k < 4; k++) cycle();
    end
    checks++;
    if (CHAR_VALID !== 1'b1 || OVERFLOW !== 1'b1 || SCROLL_COUNT !== 8'd12) begin
      failures++;
      $display("FAIL ovf_state: valid=%b ovf=%b count=%0d expected 1 1 12",
               CHAR_VALID, OVERFLOW, SCROLL_COUNT);
    end
    CHAR_READY = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (CHAR_VALID === 1'b1) got.push_back(CHAR_DATA);
      cycle();
    end
    checks++;
    if (got.size() != DEPTH) begin
      failures++;
      $display("FAIL ovf_drain_len: got %0d expected %0d", got.size(), DEPTH);
    end
    for (int i = 0; i < got.size() && i < DEPTH; i++) begin
      checks++;
      if (got[i] !== sent[i]) begin
        failures++;
        $display("FAIL ovf_drain%0d: got %0d expected %0d", i, got[i], sent[i]);
      end
    end
    checks++;
    if (OVERFLOW !== 1'b1 || CHAR_VALID !== 1'b0) begin
      failures++;
      $display("FAIL ovf_after: ovf=%b valid=%b expected 1 0", OVERFLOW, CHAR_VALID);
    end
  endtask

  task automatic test_back_to_back();
    CHAR_READY = 1'b1;
    for (int k = 0; k < 14; k++) begin
      if (k < 6) shift_in(4'($urandom_range(1, 9)));
      cycle();
      checks++;
      if (CHAR_VALID !== (exp_q.size() != 0)) begin
        failures++;
        $display("FAIL b2b_valid: got %b expected %b", CHAR_VALID, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        checks++;
        if (CHAR_DATA !== exp_q[0]) begin
          failures++;
          $display("FAIL b2b_data: got %0d expected %0d", CHAR_DATA, exp_q[0]);
        end
      end
      checks++;
      if (SCROLL_COUNT !== COUNT_W'(m_count) || FRAME_ERR !== m_ferr) begin
        failures++;
        $display("FAIL b2b_count: count=%0d ferr=%b expected %0d %b",
                 SCROLL_COUNT, FRAME_ERR, m_count, m_ferr);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0][3:0] c;
    int r, hold;
    for (int f = 0; f < 70; f++) begin
      r = $urandom_range(0, 9);
      if (r < 7) begin
        shift_in(4'($urandom_range(0, 9)));
      end else if (r < 9) begin
        for (int i = 0; i < 6; i++) c[i] = 4'($urandom_range(0, 9));
        set_frame(c);
      end
      LEDR = 10'($urandom_range(0, 511));
      hold = (f == 69) ? 12 : $urandom_range(1, 5);
      for (int h = 0; h < hold; h++) begin
        CHAR_READY = (f == 69) ? 1'b1 : ($urandom_range(0, 3) != 0);
        cycle();
        checks++;
        if (CHAR_VALID !== (exp_q.size() != 0)) begin
          failures++;
          $display("FAIL rand_valid: got %b expected %b", CHAR_VALID, exp_q.size() != 0);
        end
        if (exp_q.size() != 0) begin
          checks++;
          if (CHAR_DATA !== exp_q[0]) begin
            failures++;
            $display("FAIL rand_data: got %0d expected %0d", CHAR_DATA, exp_q[0]);
          end
        end
        checks++;
        if (SCROLL_COUNT !== COUNT_W'(m_count)) begin
          failures++;
          $display("FAIL rand_count: got %0d expected %0d", SCROLL_COUNT, m_count);
        end
        checks++;
        if ({FRAME_ERR, BAD_GLYPH, OVERFLOW, DONE} !== {m_ferr, m_bad, m_ovf, m_done}) begin
          failures++;
          $display("FAIL rand_flags: got %b%b%b%b expected %b%b%b%b",
                   FRAME_ERR, BAD_GLYPH, OVERFLOW, DONE, m_ferr, m_bad, m_ovf, m_done);
        end
      end
    end
  endtask

  task automatic test_bad_glyph_done();
    bit saw_unknown;
    bit saw_c;
    CHAR_READY = 1'b1;
    LEDR       = '0;
    for (int k = 0; k < 10; k++) cycle();
    saw_unknown = 0;
    shift_in(4'd15);   // HEX0 = 7'h55
    for (int k = 0; k < 5; k++) begin
      cycle();
      if (CHAR_VALID === 1'b1 && CHAR_DATA === 4'd15) saw_unknown = 1;
    end
    checks++;
    if (!saw_unknown || BAD_GLYPH !== 1'b1) begin
      failures++;
      $display("FAIL bad_glyph: saw_unknown=%b bad=%b expected 1 1", saw_unknown, BAD_GLYPH);
    end
    set_frame('0);
    LEDR = 10'h3FF;
    for (int k = 1; k <= LAT + 1; k++) begin
      cycle();
      checks++;
      if (DONE !== (k >= LAT)) begin
        failures++;
        $display("FAIL done_latency: cycle %0d got %b expected %b", k, DONE, k >= LAT);
      end
    end
    LEDR  = '0;
    saw_c = 0;
    shift_in(4'd1);
    for (int k = 0; k < 5; k++) begin
      cycle();
      if (CHAR_VALID === 1'b1 && CHAR_DATA === 4'd1) saw_c = 1;
    end
    checks++;
    if (!saw_c || DONE !== 1'b1 || SCROLL_COUNT !== COUNT_W'(m_count)) begin
      failures++;
      $display("FAIL after_done: saw_c=%b done=%b count=%0d expected 1 1 %0d",
               saw_c, DONE, SCROLL_COUNT, m_count);
    end
  endtask

  task automatic test_glitch();
    int pushes;
    logic [3:0] first;
    RESET_N = 1'b0;
    set_frame('0);
    LEDR       = '0;
    CHAR_READY = 1'b1;
    cycle();
    RESET_N = 1'b1;
    for (int k = 0; k < 4; k++) cycle();
    pushes = 0;
    first  = '0;
    set_frame(24'h000001);   // -----C for one cycle only
    cycle();
    set_frame('0);
    for (int k = 0; k < 7; k++) begin
      cycle();
      if (CHAR_VALID === 1'b1) begin
        if (pushes == 0) first = CHAR_DATA;
        pushes++;
      end
    end
`ifdef GLITCH_FILTER_EN
    checks++;
    if (pushes != 0 || FRAME_ERR !== 1'b0 || SCROLL_COUNT !== '0) begin
      failures++;
      $display("FAIL glitch_filtered: pushes=%0d ferr=%b count=%0d expected 0 0 0",
               pushes, FRAME_ERR, SCROLL_COUNT);
    end
`else
    // The pulse is a step; dropping back to blank is not a shift of -----C.
    checks++;
    if (pushes != 1 || first !== 4'd1 || FRAME_ERR !== 1'b1 || SCROLL_COUNT !== 8'd1) begin
      failures++;
      $display("FAIL glitch_unfiltered: pushes=%0d first=%0d ferr=%b count=%0d expected 1 1 1 1",
               pushes, first, FRAME_ERR, SCROLL_COUNT);
    end
`endif
  endtask

  task automatic test_reset_mid();
    CHAR_READY = 1'b0;
    for (int s = 0; s < 3; s++) begin
      shift_in(4'(s + 2));
      for (int k = 0; k < 4; k++) cycle();
    end
    set_frame({6{4'd3}});
    for (int k = 0; k < 4; k++) cycle();
    checks++;
    if (CHAR_VALID !== 1'b1 || FRAME_ERR !== 1'b1) begin
      failures++;
      $display("FAIL mid_prefill: valid=%b ferr=%b expected 1 1", CHAR_VALID, FRAME_ERR);
    end
    #2;
    RESET_N = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({CHAR_DATA, CHAR_VALID, SCROLL_COUNT, FRAME_ERR, BAD_GLYPH, OVERFLOW, DONE} !== '0) begin
      failures++;
      $display("FAIL mid_reset_async: data=%0d valid=%b count=%0d ferr=%b bad=%b ovf=%b done=%b, expected all 0",
               CHAR_DATA, CHAR_VALID, SCROLL_COUNT, FRAME_ERR, BAD_GLYPH, OVERFLOW, DONE);
    end
    @(negedge CLOCK_50);
    set_frame('0);
    cycle();
    RESET_N = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      checks++;
      if (CHAR_VALID !== 1'b0 || SCROLL_COUNT !== '0 || FRAME_ERR !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset_after: valid=%b count=%0d ferr=%b expected 0 0 0",
                 CHAR_VALID, SCROLL_COUNT, FRAME_ERR);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    hex_in     = {6{7'h7F}};
    LEDR       = '0;
    CHAR_READY = 1'b0;
    cur        = '0;
    test_reset();
    test_scroll_basic();
    test_frame_err();
    test_overflow();
    test_back_to_back();
    test_random();
    test_bad_glyph_done();
    test_glitch();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hex_scroll_decoder.md
Name: hex_scroll_decoder

Overview:
Passive reader for the six 7-segment displays and the LEDR bar driven by the scrolling display. It samples HEX5..HEX0 and decodes each active-low segment pattern back to a character code. It classifies every frame change as a scroll step or an illegal load. Characters that enter at HEX0 go into a small FIFO with a valid/ready drain, and the block flags end-of-message. It sits beside the scrolling display, on-chip or in benches, as a self-checking decoder.

Parameters:
DEPTH, 8, character FIFO depth (power of two, >=2)
COUNT_W, 8, width of saturating scroll-step counter

Ports:
CLOCK_50  in  1  system clock, all state on rising edge
RESET_N  in  1  asynchronous active-low reset (driven from KEY[3] at top level)
HEX5..HEX0  in  7 each  active-low segment buses; HEX5 leftmost
LEDR  in  10  LED bar from scrolling display
CHAR_DATA  out  4  head-of-FIFO character code
CHAR_VALID  out  1  FIFO non-empty
CHAR_READY  in  1  consumer accepts CHAR_DATA when VALID&READY
SCROLL_COUNT  out  COUNT_W  number of scroll steps seen, saturating
FRAME_ERR  out  1  sticky: non-shift frame change seen
BAD_GLYPH  out  1  sticky: undecodable segment pattern seen
OVERFLOW  out  1  sticky: push dropped because FIFO full
DONE  out  1  sticky: LEDR==10'h3FF with all six displays blank

Behaviour:
- Reset (async assert, sync release): all outputs 0; FIFO empty; previous-frame register P = six BLANK.
- Decode (segments 6..0): 7'h7F BLANK=0, 1000110 C=1, 0001100 P=2, 0000110 E=3, 1001000 N=4, 0110000 "3"=5, 1111001 "1"=6, 0000011 b=7, 0010001 y=8, 0000100 e=9. Any other pattern: UNKNOWN=15, and BAD_GLYPH sets.
- Pipeline: edge N registers HEX/LEDR into a sample register. Edge N+1 decodes the sample to frame F[5:0] (index 5 = HEX5), compares F against P, then updates P, the counter, the flags and the FIFO. CHAR_VALID is visible after edge N+1, giving 2-cycle latency from input to output.
- Classification at edge N+1:
  - F==P: no event.
  - F[5:1]==P[4:0] and F!=P: scroll step. Push F[0] (BLANK included). SCROLL_COUNT+1, saturating at all-ones. P<=F.
  - Any other change: FRAME_ERR<=1. P<=F. No push, no count.
- Constant nonblank F[0] with otherwise-shifted digits still counts as a scroll step (repeated letters).
- FIFO is first-word-fall-through, with CHAR_DATA = head and CHAR_VALID = !empty:
  - Pop on VALID&READY.
  - Push and pop in the same cycle, FIFO full: both occur and occupancy is unchanged.
  - Push and pop in the same cycle, FIFO empty: push only.
  - Push when full with no pop: character dropped, OVERFLOW<=1.
- DONE sets at edge N+1 when the sampled LEDR==10'h3FF and F is all BLANK. DONE stays set until reset, and later events are still processed.
- Reset asserted mid-stream clears everything immediately, including pending FIFO contents and sticky flags.

Optional Feature:
GLITCH_FILTER_EN defined: a second sample register is added. A frame is classified only when two consecutive samples match. A sample differing from its predecessor is held, not classified. Latency becomes 3 cycles, and a single-cycle glitch frame produces no event.
Not defined: every sample is classified directly with 2-cycle latency.

Decomposition:
- Package hex_scroll_pkg holds:
  - char_t, a 4-bit enum of the codes above
  - the 7-bit segment constants, including SEG_OFF
  - a seg_to_char function
  - LEDR_ALL_ON = 10'h3FF
- Sub-module char_fifo is parameterised by DEPTH and WIDTH, with push/pop/full/empty ports.

Test Plan:
- Reset held low with random HEX inputs -> all outputs 0. Release, then drive all 7'h7F -> no push, SCROLL_COUNT=0.
- Drive frames "-----C", "----CP", "---CPE" one per 4 cycles, CHAR_READY=1 -> CHAR_DATA 1,2,3 each VALID one cycle; SCROLL_COUNT=3; FRAME_ERR=0.
- From "---CPE", jump to "NNNNNN" -> FRAME_ERR=1, no push, count unchanged.
- CHAR_READY=0, 9 scroll steps with DEPTH=8 -> 8 entries held, OVERFLOW=1. Raise READY -> first 8 chars drained in order.
- HEX0=7'h55 -> BAD_GLYPH=1, UNKNOWN(15) pushed. Then LEDR=10'h3FF with all displays off -> DONE=1 two cycles later.
- With GLITCH_FILTER_EN, a one-cycle "-----C" pulse between blank frames -> no push, FRAME_ERR=0.
